dac_cfg_sequencer: RTL and testbench
====================================

# dac_cfg_sequencer

Command-driven serial configuration engine for `dac_driver`. It accepts one configuration command at a time and converts it into the GPIO bit-bang protocol that loads one of the driver's configuration registers: cycle count, mask, delay cycles, locking waveform or output-mux select. It replaces software bit-banging. It sits between the PS-side register block and the `gpio_ctrl`/`select_in` inputs of `dac_driver`, and guarantees correct setup, high and low phase lengths for every serial bit.

## Interface
Parameters:
- `PHASE_CYCLES`, default 2: length in clk cycles of each of the SETUP, HIGH and LOW phases of one serial bit. Legal range is 1 to 255.
- `MUX_PULSES`, default 8: number of serial clock pulses issued for a mux-select command.

Ports:
- `clk`  in  1  system clock; all logic is in this single domain.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd_target`  in  3  register to load: 0 cycle_count, 1 mask, 2 delay_cycle, 3 locking_waveform, 4 mux_set, 5 to 7 illegal.
- `cmd_data`  in  256  value to shift, LSB first. For mux_set only bit 0 is used.
- `gpio_ctrl`  out  16  drives `dac_driver` `gpio_ctrl`. Bit positions are the `rfsoc_config` constants `sdata`, `cycle_count_clk`, `mask_clk`, `delay_cycle_clk`, `locking_waveform_clk` and `mux_set_clk`. All other bits are driven 0.
- `select_out`  out  1  drives `dac_driver` `select_in`; high for the whole shift.
- `busy`  out  1  high in any state other than IDLE.
- `cmd_done`  out  1  one-cycle pulse when a command completes.
- `cmd_err`  out  1  one-cycle pulse, coincident with `cmd_done`, for an illegal target.

## Operation
- FSM states: IDLE, SETUP, HIGH, LOW, FINISH.
- On acceptance, latch `cmd_target` and `cmd_data`. Set the bit count to 256, or to `MUX_PULSES` for target 4, then clear the bit index to 0.
- **Legal target**, next state SETUP:
  - SETUP: `select_out`=1. `sdata` = latched_data[bit_idx], or latched_data[0] for mux_set. Target clock = 0.
  - HIGH: the target clock bit = 1. `sdata` and `select_out` are unchanged.
  - LOW: the target clock bit = 0.
  - Each of the three phases lasts exactly `PHASE_CYCLES` cycles, counted by an 8-bit phase counter.
  - At the end of LOW: if bit_idx is the last bit, go to FINISH. Otherwise increment bit_idx and go to SETUP.
- **Illegal target**: go directly to FINISH with `cmd_err` set. No select pulse and no clock pulse are issued.
- FINISH: all `gpio_ctrl` bits = 0, `select_out`=0, `cmd_done`=1 (plus `cmd_err` if illegal), then go to IDLE.
- Only the clock bit of the latched target ever toggles. No other clock bit rises during a command.
- `cmd_data` and `cmd_target` changing after acceptance have no effect.
- Reset value of every output is 0, except `cmd_ready`: it is decoded from state, so it is 1 while in reset.
- Reset asserted mid-command: all outputs go to 0 asynchronously (the `cmd_ready` exception above still applies), the command is discarded, and no `cmd_done` is issued.

## Timing
- Cycle A accepts a command.
- `select_out` rises at A+1 and stays high for N × 3 × `PHASE_CYCLES` cycles, where N is the bit count.
- For bit k, the target clock is high during cycles A+1+3Pk+P through A+1+3Pk+2P−1, where P = `PHASE_CYCLES`.
- `sdata` for bit k is valid from A+1+3Pk.
- FINISH (`cmd_done` pulse, `select_out` low) occurs at A+1+3PN. `cmd_ready` returns at A+2+3PN.
- With defaults:
  - 256-bit command: `select_out` high for 1536 cycles, `cmd_done` at A+1537, next acceptance possible at A+1538.
  - mux_set: `select_out` high for 48 cycles, `cmd_done` at A+49.
- Illegal target: `cmd_done` and `cmd_err` at A+1, `cmd_ready` at A+2.
- Back-to-back commands: at least one cycle with `select_out` = 0 (FINISH) separates any two commands.

## Test plan
- Reset with `rst`=0 for 10 cycles, then release → all outputs 0 and `cmd_ready`=1; no `gpio_ctrl` toggle for 50 idle cycles.
- Command target 1 (mask), data {8×16'h0000, 8×16'hFFFF} → 256 `mask_clk` pulses, each high for 2 cycles. `sdata` sampled at each rising edge reconstructs the data exactly. `cmd_done` at A+1537; no other clock bit ever rises.
- Command target 4, data bit 0 = 1 → exactly 8 `mux_set_clk` pulses with `sdata`=1 throughout; `select_out` high for 48 cycles.
- Command target 6 → `cmd_done` and `cmd_err` at A+1, `select_out` never rises, `cmd_ready` at A+2.
- Two queued commands (target 0 value 5, target 2 value 0) with `cmd_valid` held high → second accepted at A+1538. Bench model of `dac_driver` registers reads cycle_count=5 and delay=0.
- Reset pulsed low at bit 100 of a target 3 command → outputs 0 immediately, no `cmd_done`. A fresh command afterwards completes normally.

Source files
------------

// File: rtl/dac_cfg_sequencer.sv
// Serial configuration engine for dac_driver: turns one command into the GPIO bit-bang
// sequence (setup / clock-high / clock-low per bit) that loads a driver config register.
module dac_cfg_sequencer #(
    parameter int unsigned PHASE_CYCLES  = 2,
    parameter int unsigned MUX_PULSES    = 8,
    parameter int unsigned SDATA_BIT     = 0,
    parameter int unsigned CC_CLK_BIT    = 1,
    parameter int unsigned MASK_CLK_BIT  = 2,
    parameter int unsigned DELAY_CLK_BIT = 3,
    parameter int unsigned LOCK_CLK_BIT  = 4,
    parameter int unsigned MUX_CLK_BIT   = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_target,
    input  logic [255:0] cmd_data,
    output logic [15:0]  gpio_ctrl,
    output logic         select_out,
    output logic         busy,
    output logic         cmd_done,
    output logic         cmd_err
);

    localparam logic [7:0] PhaseLast = 8'(PHASE_CYCLES - 1);
    localparam logic [8:0] MuxCnt    = 9'(MUX_PULSES);
    localparam logic [2:0] TgtMux    = 3'd4;

    typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StFinish} state_e;

    state_e       state_q, state_d;
    logic [2:0]   target_q, target_d;
    logic [255:0] data_q, data_d;
    logic [8:0]   bit_idx_q, bit_idx_d;
    logic [8:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   phase_q, phase_d;
    logic         err_q, err_d;
    logic         phase_last;
    logic         sdata;
    logic [15:0]  clk_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            target_q  <= 3'd0;
            data_q    <= '0;
            bit_idx_q <= 9'd0;
            bit_cnt_q <= 9'd0;
            phase_q   <= 8'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            data_q    <= data_d;
            bit_idx_q <= bit_idx_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            err_q     <= err_d;
        end
    end

    assign phase_last = (phase_q == PhaseLast);

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        data_d    = data_q;
        bit_idx_d = bit_idx_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    target_d  = cmd_target;
                    data_d    = cmd_data;
                    bit_cnt_d = (cmd_target == TgtMux) ? MuxCnt : 9'd256;
                    bit_idx_d = 9'd0;
                    phase_d   = 8'd0;
                    err_d     = (cmd_target > TgtMux);
                    state_d   = (cmd_target > TgtMux) ? StFinish : StSetup;
                end
            end
            StSetup, StHigh: begin
                if (phase_last) begin
                    phase_d = 8'd0;
                    state_d = (state_q == StSetup) ? StHigh : StLow;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            StLow: begin
                if (phase_last) begin
                    phase_d = 8'd0;
                    if (bit_idx_q == bit_cnt_q - 9'd1) begin
                        state_d = StFinish;
                    end else begin
                        bit_idx_d = bit_idx_q + 9'd1;
                        state_d   = StSetup;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        clk_mask = '0;
        case (target_q)
            3'd0:    clk_mask[CC_CLK_BIT]    = 1'b1;
            3'd1:    clk_mask[MASK_CLK_BIT]  = 1'b1;
            3'd2:    clk_mask[DELAY_CLK_BIT] = 1'b1;
            3'd3:    clk_mask[LOCK_CLK_BIT]  = 1'b1;
            3'd4:    clk_mask[MUX_CLK_BIT]   = 1'b1;
            default: clk_mask = '0;
        endcase
    end

    // mux_set repeats bit 0 on every pulse instead of walking the data word
    assign sdata = (target_q == TgtMux) ? data_q[0] : data_q[bit_idx_q[7:0]];

    always_comb begin
        gpio_ctrl  = '0;
        select_out = 1'b0;
        cmd_done   = 1'b0;
        cmd_err    = 1'b0;
        cmd_ready  = (state_q == StIdle);
        busy       = (state_q != StIdle);
        if (state_q == StSetup || state_q == StHigh || state_q == StLow) begin
            select_out           = 1'b1;
            gpio_ctrl[SDATA_BIT] = sdata;
            if (state_q == StHigh) begin
                gpio_ctrl = gpio_ctrl | clk_mask;
            end
        end
        if (state_q == StFinish) begin
            cmd_done = 1'b1;
            cmd_err  = err_q;
        end
    end

endmodule

// File: tb/tb_dac_cfg_sequencer.sv
// Directed bench for dac_cfg_sequencer with a shift-register model of the dac_driver
// configuration registers fed from the GPIO outputs.
module tb_dac_cfg_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_target;
    logic [255:0] cmd_data;
    logic [15:0]  gpio_ctrl;
    logic         select_out;
    logic         busy;
    logic         cmd_done;
    logic         cmd_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic         model_clr = 1'b0;
    logic [255:0] m_cc, m_mask, m_delay, m_lock;

    always #5 clk = ~clk;

    dac_cfg_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_data   (cmd_data),
        .gpio_ctrl  (gpio_ctrl),
        .select_out (select_out),
        .busy       (busy),
        .cmd_done   (cmd_done),
        .cmd_err    (cmd_err)
    );

    // dac_driver model: each register shifts sdata in at the rising edge of its clock, LSB first
    always @(posedge gpio_ctrl[1] or posedge gpio_ctrl[2] or posedge gpio_ctrl[3]
             or posedge gpio_ctrl[4] or posedge model_clr) begin
        if (model_clr) begin
            m_cc    = '1;
            m_mask  = '1;
            m_delay = '1;
            m_lock  = '1;
        end else begin
            if (gpio_ctrl[1]) m_cc    = {gpio_ctrl[0], m_cc[255:1]};
            if (gpio_ctrl[2]) m_mask  = {gpio_ctrl[0], m_mask[255:1]};
            if (gpio_ctrl[3]) m_delay = {gpio_ctrl[0], m_delay[255:1]};
            if (gpio_ctrl[4]) m_lock  = {gpio_ctrl[0], m_lock[255:1]};
        end
    end

    task automatic clear_model();
        model_clr = 1'b1;
        #1 model_clr = 1'b0;
    endtask

    // Issue one command and observe it cycle by cycle; c counts cycles after acceptance cycle A.
    task automatic run_cmd(input logic [2:0] tgt, input logic [255:0] data, input int limit,
                           output int done_at, output int err_at, output int ready_at,
                           output int sel_cycles, output int pulses, output int ones,
                           output logic other_rise, output logic bad_high);
        logic [15:0] prev_g, rises, falls;
        int tb_bit, hi;
        done_at = -1; err_at = -1; ready_at = -1;
        sel_cycles = 0; pulses = 0; ones = 0; hi = 0;
        other_rise = 1'b0; bad_high = 1'b0;
        tb_bit = (tgt < 3'd5) ? int'(tgt) + 1 : -1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_target = tgt; cmd_data = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_target = 3'd0; cmd_data = ~data;
        prev_g = 16'h0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (select_out) sel_cycles++;
            if (cmd_done && done_at < 0) done_at = c;
            if (cmd_err && err_at < 0) err_at = c;
            if (cmd_ready && done_at >= 0) begin
                ready_at = c;
                break;
            end
            rises = gpio_ctrl & ~prev_g;
            falls = prev_g & ~gpio_ctrl;
            for (int b = 1; b < 16; b++)
                if (rises[b] && b != tb_bit) other_rise = 1'b1;
            if (tb_bit > 0) begin
                if (rises[tb_bit]) begin
                    pulses++;
                    if (gpio_ctrl[0]) ones++;
                    hi = 1;
                end else if (gpio_ctrl[tb_bit]) begin
                    hi++;
                end
                if (falls[tb_bit] && hi != 2) bad_high = 1'b1;
            end
            prev_g = gpio_ctrl;
        end
    endtask

    task automatic test_reset();
        logic toggled;
        rst = 1'b0; cmd_valid = 1'b0; cmd_target = 3'd0; cmd_data = '0;
        repeat (10) @(negedge clk);
        tests_run++;
        if ({gpio_ctrl, select_out, busy, cmd_done, cmd_err, cmd_ready} !== {16'h0, 4'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_hold: outs=%h sel=%b busy=%b done=%b err=%b rdy=%b, want 0s and rdy=1",
                     gpio_ctrl, select_out, busy, cmd_done, cmd_err, cmd_ready);
        end
        rst = 1'b1;
        toggled = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gpio_ctrl !== 16'h0 || select_out !== 1'b0) toggled = 1'b1;
        end
        tests_run++;
        if (toggled !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle_quiet: gpio activity seen=%b, want 0", toggled);
        end
        tests_run++;
        if ({busy, cmd_done, cmd_err, cmd_ready} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_idle_status: busy/done/err/rdy=%b, want 0001",
                     {busy, cmd_done, cmd_err, cmd_ready});
        end
    endtask

    task automatic test_mask();
        logic [255:0] d;
        int done_at, err_at, ready_at, sel, pulses, ones;
        logic other, badh;
        d = {{8{16'h0000}}, {8{16'hFFFF}}};
        clear_model();
        run_cmd(3'd1, d, 2000, done_at, err_at, ready_at, sel, pulses, ones, other, badh);
        tests_run++;
        if (done_at !== 1537) begin
            tests_failed++; $display("FAIL mask_done_at: got %0d want 1537", done_at);
        end
        tests_run++;
        if (ready_at !== 1538) begin
            tests_failed++; $display("FAIL mask_ready_at: got %0d want 1538", ready_at);
        end
        tests_run++;
        if (sel !== 1536) begin
            tests_failed++; $display("FAIL mask_select_len: got %0d want 1536", sel);
        end
        tests_run++;
        if (pulses !== 256 || badh !== 1'b0) begin
            tests_failed++;
            $display("FAIL mask_pulses: got %0d bad_high=%b want 256 and 0", pulses, badh);
        end
        tests_run++;
        if (m_mask !== d) begin
            tests_failed++; $display("FAIL mask_data: got %h want %h", m_mask, d);
        end
        tests_run++;
        if (other !== 1'b0 || err_at !== -1) begin
            tests_failed++;
            $display("FAIL mask_clean: other_rise=%b err_at=%0d want 0 and -1", other, err_at);
        end
    endtask

    task automatic test_mux();
        int done_at, err_at, ready_at, sel, pulses, ones;
        logic other, badh;
        run_cmd(3'd4, 256'hA5, 200, done_at, err_at, ready_at, sel, pulses, ones, other, badh);
        tests_run++;
        if (pulses !== 8 || ones !== 8) begin
            tests_failed++;
            $display("FAIL mux_pulses: pulses=%0d sdata_ones=%0d want 8 and 8", pulses, ones);
        end
        tests_run++;
        if (sel !== 48 || done_at !== 49) begin
            tests_failed++;
            $display("FAIL mux_timing: sel=%0d done_at=%0d want 48 and 49", sel, done_at);
        end
        tests_run++;
        if (other !== 1'b0 || badh !== 1'b0) begin
            tests_failed++;
            $display("FAIL mux_clean: other_rise=%b bad_high=%b want 0", other, badh);
        end
    endtask

    task automatic test_illegal();
        int done_at, err_at, ready_at, sel, pulses, ones;
        logic other, badh;
        run_cmd(3'd6, 256'hFFFF, 20, done_at, err_at, ready_at, sel, pulses, ones, other, badh);
        tests_run++;
        if (done_at !== 1 || err_at !== 1) begin
            tests_failed++;
            $display("FAIL illegal_done_err: done_at=%0d err_at=%0d want 1 and 1", done_at, err_at);
        end
        tests_run++;
        if (ready_at !== 2) begin
            tests_failed++; $display("FAIL illegal_ready: got %0d want 2", ready_at);
        end
        tests_run++;
        if (sel !== 0 || other !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_quiet: sel=%0d other_rise=%b want 0 and 0", sel, other);
        end
    endtask

    task automatic test_back_to_back();
        int acc2, done2;
        logic gap_ok;
        acc2 = -1; done2 = -1; gap_ok = 1'b0;
        clear_model();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_target = 3'd0; cmd_data = 256'd5;
        @(posedge clk);
        #1;
        cmd_target = 3'd2; cmd_data = 256'd0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (c == 1537 && select_out === 1'b0 && cmd_done === 1'b1) gap_ok = 1'b1;
            if (cmd_ready && cmd_valid) begin
                acc2 = c;
                break;
            end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (cmd_done) begin
                done2 = c;
                break;
            end
        end
        tests_run++;
        if (acc2 !== 1538 || gap_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_accept: second accept at %0d gap=%b want 1538 and 1", acc2, gap_ok);
        end
        tests_run++;
        if (done2 !== 1537) begin
            tests_failed++; $display("FAIL b2b_done2: got %0d want 1537", done2);
        end
        tests_run++;
        if (m_cc !== 256'd5 || m_delay !== 256'd0) begin
            tests_failed++;
            $display("FAIL b2b_regs: cycle_count=%h delay=%h want 5 and 0", m_cc, m_delay);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [255:0] d;
        logic done_seen;
        int done_at, err_at, ready_at, sel, pulses, ones;
        logic other, badh;
        done_seen = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_target = 3'd3; cmd_data = {8{32'hDEAD_BEEF}};
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (603) @(negedge clk);
        tests_run++;
        if (gpio_ctrl[4] !== 1'b1) begin
            tests_failed++; $display("FAIL mid_in_high: lock clk=%b want 1", gpio_ctrl[4]);
        end
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({gpio_ctrl, select_out, busy, cmd_done, cmd_err, cmd_ready} !== {16'h0, 4'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL mid_reset_outs: gpio=%h sel=%b busy=%b done=%b err=%b rdy=%b want 0s rdy=1",
                     gpio_ctrl, select_out, busy, cmd_done, cmd_err, cmd_ready);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_done || gpio_ctrl != 16'h0) done_seen = 1'b1;
        end
        tests_run++;
        if (done_seen !== 1'b0) begin
            tests_failed++; $display("FAIL mid_no_done: activity after reset=%b want 0", done_seen);
        end
        d = {4{64'h0123_4567_89AB_CDEF}};
        clear_model();
        run_cmd(3'd3, d, 2000, done_at, err_at, ready_at, sel, pulses, ones, other, badh);
        tests_run++;
        if (done_at !== 1537 || m_lock !== d) begin
            tests_failed++;
            $display("FAIL mid_fresh_cmd: done_at=%0d lock=%h want 1537 and %h", done_at, m_lock, d);
        end
    endtask

    initial begin
        test_reset();
        test_mask();
        test_mux();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
